// File: rtl/key_debounce.sv
// Push-button conditioning: per-channel 2-flop synchroniser, stability-count
// debounce filter, press/release pulses and an optional auto-repeat generator.

module key_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic held_o,
  output logic held_d_o,
  output logic press_o,
  output logic rls_o,
  output logic rpt_o
);
  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW   = $clog2(HMAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] DLY_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PER_LAST = HW'(REPEAT_PERIOD - 1);
  localparam logic          REL_LVL  = ACTIVE_LOW;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_RPT   = 2'd2;

  logic          s1_q, s2_q, p;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          held_q, held_d, press_q, press_d, rls_q, rls_d, rpt_q, rpt_d;
  logic [1:0]    st_q, st_d;
  logic [HW-1:0] hcnt_q, hcnt_d;

  assign p = ACTIVE_LOW ? ~s2_q : s2_q;

  always_comb begin
    cnt_d   = cnt_q;
    held_d  = held_q;
    press_d = 1'b0;
    rls_d   = 1'b0;
    // Any sample agreeing with the accepted level restarts the stability count.
    if (p == held_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      held_d  = p;
      cnt_d   = '0;
      press_d = p;
      rls_d   = ~p;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    st_d   = st_q;
    hcnt_d = hcnt_q;
    rpt_d  = 1'b0;
    // Release wins over any pending repeat tick in the same cycle.
    if (rls_d) begin
      st_d   = ST_IDLE;
      hcnt_d = '0;
    end else if (press_d && REPEAT_EN) begin
      st_d   = ST_DELAY;
      hcnt_d = '0;
    end else begin
      case (st_q)
        ST_DELAY: begin
          if (hcnt_q == DLY_LAST) begin
            rpt_d  = 1'b1;
            st_d   = ST_RPT;
            hcnt_d = '0;
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end
        ST_RPT: begin
          if (hcnt_q == PER_LAST) begin
            rpt_d  = 1'b1;
            hcnt_d = '0;
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end
        default: begin
          st_d   = ST_IDLE;
          hcnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= REL_LVL;
      s2_q    <= REL_LVL;
      cnt_q   <= '0;
      held_q  <= 1'b0;
      press_q <= 1'b0;
      rls_q   <= 1'b0;
      rpt_q   <= 1'b0;
      st_q    <= ST_IDLE;
      hcnt_q  <= '0;
    end else begin
      s1_q    <= key_i;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      press_q <= press_d;
      rls_q   <= rls_d;
      rpt_q   <= rpt_d;
      st_q    <= st_d;
      hcnt_q  <= hcnt_d;
    end
  end

  assign held_o   = held_q;
  assign held_d_o = held_d;
  assign press_o  = press_q;
  assign rls_o    = rls_q;
  assign rpt_o    = rpt_q;
endmodule

module key_debounce #(
  parameter int N_KEYS          = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] held,
  output logic [N_KEYS-1:0] press,
  output logic [N_KEYS-1:0] rls,
  output logic [N_KEYS-1:0] rpt,
  output logic              any_held
);
  logic [N_KEYS-1:0] held_d;
  logic              any_held_q;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .REPEAT_EN      (REPEAT_EN),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_i   (key_raw[g]),
      .held_o  (held[g]),
      .held_d_o(held_d[g]),
      .press_o (press[g]),
      .rls_o   (rls[g]),
      .rpt_o   (rpt[g])
    );
  end

  // Built from next-state held so it changes on the same edge as held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) any_held_q <= 1'b0;
    else        any_held_q <= |held_d;
  end

  assign any_held = any_held_q;
endmodule

// File: tb/tb_key_debounce.sv
// Randomised + directed bench for key_debounce; a history-based reference model
// feeds an expected-value queue that a separate monitor drains every cycle.

module tb_key_debounce;
  localparam int N  = 3;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam int MAXE = 16384;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] key_raw = '1;
  logic [N-1:0] held, press, rls, rpt;
  logic         any_held;

  key_debounce #(
    .N_KEYS(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1), .REPEAT_EN(1'b1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_raw(key_raw), .held(held), .press(press),
    .rls(rls), .rpt(rpt), .any_held(any_held)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  // pr[e][c]: was the raw pin "pressed" when sampled at edge e (0 while in reset).
  bit [N-1:0]   pr [0:MAXE-1];
  int           e = 0;
  bit [N-1:0]   m_held = '0;
  int           last_chg [N];
  int           press_e [N];
  logic [4*N:0] exp_q [$];

  function automatic bit pr_at(int idx, int c);
    if (idx < 0) return 1'b0;
    return pr[idx][c];
  endfunction

  initial begin
    for (int c = 0; c < N; c++) begin
      last_chg[c] = 0;
      press_e[c]  = -1;
    end
  end

  always @(posedge clk) begin
    bit [N-1:0] m_press, m_rls, m_rpt;
    bit         stable;
    m_press = '0; m_rls = '0; m_rpt = '0;
    if (!rst_n) begin
      pr[e]  = '0;
      m_held = '0;
      for (int c = 0; c < N; c++) begin
        last_chg[c] = e;
        press_e[c]  = -1;
      end
    end else begin
      pr[e] = ~key_raw;
      for (int c = 0; c < N; c++) begin
        // The filter sees at edge t the pin value sampled at edge t-2; a level is
        // accepted after D consecutive filter samples differing from held.
        stable = (e - last_chg[c]) >= D;
        for (int j = 0; j < D; j++)
          if (pr_at(e - 2 - j, c) == m_held[c]) stable = 1'b0;
        if (stable) begin
          m_held[c]   = ~m_held[c];
          last_chg[c] = e;
          if (m_held[c]) begin m_press[c] = 1'b1; press_e[c] = e; end
          else begin m_rls[c] = 1'b1; press_e[c] = -1; end
        end
        if (m_held[c] && press_e[c] >= 0 && (e - press_e[c]) >= RD &&
            ((e - press_e[c] - RD) % RP) == 0)
          m_rpt[c] = 1'b1;
      end
    end
    exp_q.push_back({|m_held, m_rpt, m_rls, m_press, m_held});
    e++;
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [4*N:0] ex, act;
    if (exp_q.size() > 0) begin
      ex  = exp_q.pop_front();
      act = {any_held, rpt, rls, press, held};
      vectors++;
      if (act !== ex) begin
        miscompares++;
        $display("FAIL outputs @%0t: got any=%b rpt=%b rls=%b press=%b held=%b, want any=%b rpt=%b rls=%b press=%b held=%b",
                 $time, act[4*N], act[4*N-1:3*N], act[3*N-1:2*N], act[2*N-1:N], act[N-1:0],
                 ex[4*N], ex[4*N-1:3*N], ex[3*N-1:2*N], ex[2*N-1:N], ex[N-1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_key(int c, bit v);
    key_raw[c] = v;
  endtask

  task automatic check_zero(string name);
    logic [4*N:0] act;
    act = {any_held, rpt, rls, press, held};
    vectors++;
    if (act !== '0) begin
      miscompares++;
      $display("FAIL %s: outputs=%b, want all zero", name, act);
    end
  endtask

  task automatic reset_pulse(int low_cycles, string name);
    @(negedge clk); #2 rst_n = 1'b0;
    #1 check_zero(name);
    cyc(low_cycles);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    // Async reset with all keys low; outputs must clear before any clock edge.
    #2 key_raw = 3'b000; rst_n = 1'b0;
    #1 check_zero("async_reset");
    cyc(6);
    #2 rst_n = 1'b1;
    cyc(20);
    key_raw = 3'b111;
    cyc(12);

    // Glitch shorter than the debounce window on key 0.
    set_key(0, 0); cyc(3); set_key(0, 1); cyc(10);

    // Bounce on key 1 press and release.
    for (int i = 0; i < 2; i++) begin set_key(1, 1); cyc(2); set_key(1, 0); cyc(2); end
    cyc(10);
    for (int i = 0; i < 2; i++) begin set_key(1, 1); cyc(2); set_key(1, 0); cyc(2); end
    set_key(1, 1); cyc(12);

    // Auto-repeat on key 2.
    set_key(2, 0); cyc(28); set_key(2, 1); cyc(12);

    // Simultaneous press on keys 0 and 1, staggered release.
    key_raw = 3'b100; cyc(14);
    set_key(0, 1); cyc(12);
    set_key(1, 1); cyc(10);

    // Reset while key 2 is in the repeat phase, key kept held through it.
    set_key(2, 0); cyc(22);
    reset_pulse(3, "reset_mid_repeat");
    cyc(25);
    set_key(2, 1); cyc(10);

    // Random bouncing with alternating calm and noisy phases.
    for (int ph = 0; ph < 30; ph++) begin
      int pmax;
      pmax = (ph % 2) ? 3 : 40;
      for (int t = 0; t < 50; t++) begin
        for (int c = 0; c < N; c++)
          if ($urandom_range(0, pmax - 1) == 0) key_raw[c] = ~key_raw[c];
        cyc(1);
      end
      if (ph == 17) reset_pulse($urandom_range(1, 4), "reset_random");
    end

    key_raw = '1;
    cyc(15);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
